// File: rtl/hazard_scheduler.sv
// Hazard controller for the five-stage MIPS pipeline: forwarding selects,
// load-use/branch/MDU stalls and the multi-cycle multiply/divide scheduler.
module hazard_scheduler #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic       branch_d,
    input  logic       mdu_op_d,
    input  logic       mfhilo_d,
    input  logic [4:0] rs_e,
    input  logic [4:0] rt_e,
    input  logic [4:0] wreg_e,
    input  logic [4:0] wreg_m,
    input  logic [4:0] wreg_w,
    input  logic       regwrite_e,
    input  logic       regwrite_m,
    input  logic       regwrite_w,
    input  logic       memtoreg_e,
    input  logic       memtoreg_m,
    input  logic       mdu_start_e,
    input  logic       mdu_div_e,
    output logic       stall_f,
    output logic       stall_d,
    output logic       flush_e,
    output logic [1:0] fwd_a_e,
    output logic [1:0] fwd_b_e,
    output logic       fwd_a_d,
    output logic       fwd_b_d,
    output logic       mdu_busy,
    output logic       mdu_done
);

    localparam int unsigned RegW = 5;
    localparam int unsigned CntW = 6;
    localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 1);
    localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              busy_q, done_q;

    // A stage supplies source s when it writes a nonzero register equal to s.
    function automatic logic stage_match(input logic rw, input logic [RegW-1:0] wr,
                                         input logic [RegW-1:0] s);
        return rw && (wr != '0) && (wr == s);
    endfunction

    // Forwarding selects and combined stall; all held low during reset.
    always_comb begin
        logic lwstall, brstall, mdustall, stall;
        fwd_a_e  = 2'b00;
        fwd_b_e  = 2'b00;
        fwd_a_d  = 1'b0;
        fwd_b_d  = 1'b0;
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        flush_e  = 1'b0;
        lwstall  = memtoreg_e && (stage_match(regwrite_e, wreg_e, rs_d) ||
                                  stage_match(regwrite_e, wreg_e, rt_d));
        brstall  = branch_d && (stage_match(regwrite_e, wreg_e, rs_d) ||
                                stage_match(regwrite_e, wreg_e, rt_d) ||
                                (memtoreg_m && (stage_match(regwrite_m, wreg_m, rs_d) ||
                                                stage_match(regwrite_m, wreg_m, rt_d))));
        mdustall = (mdu_op_d || mfhilo_d) && (busy_q || mdu_start_e);
        stall    = lwstall || brstall || mdustall;
        if (!rst) begin
            if (stage_match(regwrite_m, wreg_m, rs_e))      fwd_a_e = 2'b10;
            else if (stage_match(regwrite_w, wreg_w, rs_e)) fwd_a_e = 2'b01;
            if (stage_match(regwrite_m, wreg_m, rt_e))      fwd_b_e = 2'b10;
            else if (stage_match(regwrite_w, wreg_w, rt_e)) fwd_b_e = 2'b01;
            fwd_a_d = stage_match(regwrite_m, wreg_m, rs_d);
            fwd_b_d = stage_match(regwrite_m, wreg_m, rt_d);
            stall_f = stall;
            stall_d = stall;
            flush_e = stall;
        end
    end

    // MDU scheduler next-state; start during BUSY is architecturally impossible.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (mdu_start_e) begin
                    state_d = BUSY;
                    cnt_d   = mdu_div_e ? DivLoad : MulLoad;
                end
            end
            BUSY: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            DONE: begin
                if (mdu_start_e) begin
                    state_d = BUSY;
                    cnt_d   = mdu_div_e ? DivLoad : MulLoad;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == BUSY);
            done_q  <= (state_d == DONE);
        end
    end

    assign mdu_busy = busy_q;
    assign mdu_done = done_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed plus randomized bench for hazard_scheduler; two instances cover
// the default latencies and the single-cycle multiply corner.
module tb_hazard_scheduler;

    localparam int MUL0 = 4;
    localparam int DIV0 = 32;
    localparam int MUL1 = 1;
    localparam int DIV1 = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
    logic       branch_d, mdu_op_d, mfhilo_d;
    logic       regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m;
    logic       mdu_start_e, mdu_div_e;

    logic       o_stall_f [2];
    logic       o_stall_d [2];
    logic       o_flush_e [2];
    logic [1:0] o_fwd_a_e [2];
    logic [1:0] o_fwd_b_e [2];
    logic       o_fwd_a_d [2];
    logic       o_fwd_b_d [2];
    logic       o_busy    [2];
    logic       o_done    [2];

    int cyc = 0;
    int st_t [2];
    int st_n [2];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scheduler #(.MUL_CYCLES(MUL0), .DIV_CYCLES(DIV0)) u_dut0 (
        .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d),
        .mdu_op_d(mdu_op_d), .mfhilo_d(mfhilo_d), .rs_e(rs_e), .rt_e(rt_e),
        .wreg_e(wreg_e), .wreg_m(wreg_m), .wreg_w(wreg_w),
        .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
        .mdu_start_e(mdu_start_e), .mdu_div_e(mdu_div_e),
        .stall_f(o_stall_f[0]), .stall_d(o_stall_d[0]), .flush_e(o_flush_e[0]),
        .fwd_a_e(o_fwd_a_e[0]), .fwd_b_e(o_fwd_b_e[0]),
        .fwd_a_d(o_fwd_a_d[0]), .fwd_b_d(o_fwd_b_d[0]),
        .mdu_busy(o_busy[0]), .mdu_done(o_done[0]));

    hazard_scheduler #(.MUL_CYCLES(MUL1), .DIV_CYCLES(DIV1)) u_dut1 (
        .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d),
        .mdu_op_d(mdu_op_d), .mfhilo_d(mfhilo_d), .rs_e(rs_e), .rt_e(rt_e),
        .wreg_e(wreg_e), .wreg_m(wreg_m), .wreg_w(wreg_w),
        .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
        .mdu_start_e(mdu_start_e), .mdu_div_e(mdu_div_e),
        .stall_f(o_stall_f[1]), .stall_d(o_stall_d[1]), .flush_e(o_flush_e[1]),
        .fwd_a_e(o_fwd_a_e[1]), .fwd_b_e(o_fwd_b_e[1]),
        .fwd_a_d(o_fwd_a_d[1]), .fwd_b_d(o_fwd_b_d[1]),
        .mdu_busy(o_busy[1]), .mdu_done(o_done[1]));

    // Reference: an MDU started in cycle t is busy in t+1..t+N and done in t+N+1.
    function automatic logic m_busy(int k);
        return (st_t[k] >= 0) && (cyc > st_t[k]) && (cyc <= st_t[k] + st_n[k]);
    endfunction

    function automatic logic m_done(int k);
        return (st_t[k] >= 0) && (cyc == st_t[k] + st_n[k] + 1);
    endfunction

    function automatic logic mt(logic rw, logic [4:0] wr, logic [4:0] s);
        return rw && (wr != 5'd0) && (wr == s);
    endfunction

    task automatic chk(string tag, int k, logic [1:0] obs, logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cyc=%0d observed=%0d expected=%0d", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [1:0] ea, eb;
        logic lw, br, md, st;
        if (rst) begin
            st_t[0] = -1000;
            st_t[1] = -1000;
        end
        ea = mt(regwrite_m, wreg_m, rs_e) ? 2'b10 : mt(regwrite_w, wreg_w, rs_e) ? 2'b01 : 2'b00;
        eb = mt(regwrite_m, wreg_m, rt_e) ? 2'b10 : mt(regwrite_w, wreg_w, rt_e) ? 2'b01 : 2'b00;
        lw = memtoreg_e && (mt(regwrite_e, wreg_e, rs_d) || mt(regwrite_e, wreg_e, rt_d));
        br = branch_d && (mt(regwrite_e, wreg_e, rs_d) || mt(regwrite_e, wreg_e, rt_d) ||
             (memtoreg_m && (mt(regwrite_m, wreg_m, rs_d) || mt(regwrite_m, wreg_m, rt_d))));
        for (int k = 0; k < 2; k++) begin
            md = (mdu_op_d || mfhilo_d) && (m_busy(k) || mdu_start_e);
            st = (lw || br || md) && !rst;
            chk("fwd_a_e", k, o_fwd_a_e[k], rst ? 2'b00 : ea);
            chk("fwd_b_e", k, o_fwd_b_e[k], rst ? 2'b00 : eb);
            chk("fwd_a_d", k, 2'(o_fwd_a_d[k]), 2'(!rst && mt(regwrite_m, wreg_m, rs_d)));
            chk("fwd_b_d", k, 2'(o_fwd_b_d[k]), 2'(!rst && mt(regwrite_m, wreg_m, rt_d)));
            chk("stall_f", k, 2'(o_stall_f[k]), 2'(st));
            chk("stall_d", k, 2'(o_stall_d[k]), 2'(st));
            chk("flush_e", k, 2'(o_flush_e[k]), 2'(st));
            chk("mdu_busy", k, 2'(o_busy[k]), 2'(m_busy(k)));
            chk("mdu_done", k, 2'(o_done[k]), 2'(m_done(k)));
        end
    endtask

    // Check mid-cycle, then let the clock edge consume the inputs.
    task automatic run_cycle();
        #1 check_all();
        @(posedge clk);
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (mdu_start_e && !m_busy(k)) begin
                    st_t[k] = cyc;
                    st_n[k] = mdu_div_e ? (k == 0 ? DIV0 : DIV1) : (k == 0 ? MUL0 : MUL1);
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_in();
        {rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w} = '0;
        {branch_d, mdu_op_d, mfhilo_d, regwrite_e, regwrite_m, regwrite_w} = '0;
        {memtoreg_e, memtoreg_m, mdu_start_e, mdu_div_e} = '0;
    endtask

    initial begin
        st_t[0] = -1000; st_t[1] = -1000;
        st_n[0] = 0;     st_n[1] = 0;
        clear_in();
        rst = 1'b1;
        rs_e = 5'd5; regwrite_m = 1'b1; wreg_m = 5'd5;
        @(negedge clk);
        run_cycle();
        run_cycle();
        rst = 1'b0;

        // Forwarding priority
        rs_e = 5'd5; regwrite_m = 1'b1; wreg_m = 5'd5; regwrite_w = 1'b1; wreg_w = 5'd5;
        run_cycle();
        chk("prio_mem", 0, o_fwd_a_e[0], 2'b10);
        regwrite_m = 1'b0;
        run_cycle();
        chk("prio_wb", 0, o_fwd_a_e[0], 2'b01);
        wreg_m = 5'd0; wreg_w = 5'd0; rs_e = 5'd0; regwrite_m = 1'b1;
        run_cycle();
        chk("prio_zero", 0, o_fwd_a_e[0], 2'b00);

        // Load-use
        clear_in();
        memtoreg_e = 1'b1; regwrite_e = 1'b1; wreg_e = 5'd8; rt_d = 5'd8;
        run_cycle();
        chk("lw_stall", 0, 2'(o_stall_d[0]), 2'b01);
        wreg_e = 5'd0; rt_d = 5'd0;
        run_cycle();
        chk("lw_r0", 0, 2'(o_flush_e[0]), 2'b00);

        // Branch compare: EX stall then MEM forward
        clear_in();
        branch_d = 1'b1; rs_d = 5'd3; regwrite_e = 1'b1; wreg_e = 5'd3;
        run_cycle();
        chk("br_stall", 0, 2'(o_stall_f[0]), 2'b01);
        regwrite_e = 1'b0; wreg_e = 5'd0; regwrite_m = 1'b1; wreg_m = 5'd3;
        run_cycle();
        chk("br_fwd", 0, 2'(o_fwd_a_d[0]), 2'b01);
        chk("br_nostall", 0, 2'(o_stall_f[0]), 2'b00);

        // Multiply with dependent mfhi held; then back-to-back start in DONE
        clear_in();
        mfhilo_d = 1'b1; mdu_start_e = 1'b1;
        run_cycle();
        mdu_start_e = 1'b0;
        for (int i = 0; i < MUL0; i++) run_cycle();
        chk("mul_done", 0, 2'(o_done[0]), 2'b01);
        chk("mul_release", 0, 2'(o_stall_d[0]), 2'b00);
        mdu_start_e = 1'b1;
        run_cycle();
        mdu_start_e = 1'b0;
        run_cycle();
        chk("b2b_busy", 0, 2'(o_busy[0]), 2'b01);
        chk("b2b_done_once", 0, 2'(o_done[0]), 2'b00);
        for (int i = 0; i < MUL0 + 2; i++) run_cycle();

        // Divide interrupted by reset in its 10th busy cycle
        clear_in();
        mdu_start_e = 1'b1; mdu_div_e = 1'b1;
        run_cycle();
        mdu_start_e = 1'b0; mdu_op_d = 1'b1;
        for (int i = 0; i < 9; i++) run_cycle();
        chk("div_busy", 0, 2'(o_busy[0]), 2'b01);
        rst = 1'b1;
        run_cycle();
        chk("rst_busy", 0, 2'(o_busy[0]), 2'b00);
        run_cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) run_cycle();
        chk("post_rst_idle", 0, 2'(o_stall_d[0]), 2'b00);

        // Randomized traffic; starts only when no model instance is busy
        for (int n = 0; n < 800; n++) begin
            rs_d = 5'($urandom_range(0, 3));   rt_d = 5'($urandom_range(0, 3));
            rs_e = 5'($urandom_range(0, 3));   rt_e = 5'($urandom_range(0, 3));
            wreg_e = 5'($urandom_range(0, 3)); wreg_m = 5'($urandom_range(0, 3));
            wreg_w = 5'($urandom_range(0, 3));
            {branch_d, mdu_op_d, mfhilo_d} = 3'($urandom);
            {regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m} = 5'($urandom);
            mdu_div_e   = 1'($urandom_range(0, 3) == 0);
            mdu_start_e = !m_busy(0) && !m_busy(1) && ($urandom_range(0, 3) == 0);
            rst         = ($urandom_range(0, 99) == 0);
            run_cycle();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scheduler.md
# hazard_scheduler

Pipeline hazard controller for the five-stage MIPS core. Combinationally computes EX-stage and decode-stage forwarding selects and the load-use and branch-compare stalls. Sequentially schedules the multi-cycle multiply/divide unit (MDU) with a busy FSM and cycle counter that hold back dependent instructions. It sits beside the pipeline registers and drives their stall/flush enables and the forwarding muxes feeding the ALU and the branch comparator.

## Interface
- MUL_CYCLES, 4, multiply latency in BUSY cycles (1..63)
- DIV_CYCLES, 32, divide latency in BUSY cycles (1..63)

- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rs_d, rt_d  in  5  decode-stage source registers
- branch_d  in  1  decode-stage instruction is a register-compare branch
- mdu_op_d  in  1  decode-stage instruction is mult/div
- mfhilo_d  in  1  decode-stage instruction reads HI/LO
- rs_e, rt_e  in  5  EX-stage source registers
- wreg_e, wreg_m, wreg_w  in  5  destination register in EX/MEM/WB
- regwrite_e, regwrite_m, regwrite_w  in  1  RegWrite in EX/MEM/WB
- memtoreg_e, memtoreg_m  in  1  MemToReg (load) in EX/MEM
- mdu_start_e  in  1  valid mult/div in EX this cycle
- mdu_div_e  in  1  EX MDU op is divide (1) or multiply (0)
- stall_f, stall_d  out  1  hold PC / IF-ID register
- flush_e  out  1  clear ID-EX register (bubble)
- fwd_a_e, fwd_b_e  out  2  ALU operand select: 00 regfile, 01 WB result, 10 MEM ALU result
- fwd_a_d, fwd_b_d  out  1  branch comparator takes MEM ALU result
- mdu_busy  out  1  MDU FSM in BUSY
- mdu_done  out  1  one-cycle pulse, HI/LO valid

## Operation
- Register match rule: a stage matches source `s` when its regwrite is 1, its wreg ≠ 0, and wreg == s. $0 is never forwarded or stalled on.
- fwd_a_e: 10 if MEM matches rs_e; else 01 if WB matches rs_e; else 00. MEM has priority. fwd_b_e is the same with rt_e.
- fwd_a_d = MEM matches rs_d; fwd_b_d = MEM matches rt_d.
- lwstall = memtoreg_e & (EX matches rs_d | EX matches rt_d).
- brstall = branch_d & ((EX matches rs_d or rt_d) | (memtoreg_m & MEM matches rs_d or rt_d)).
- mdustall = (mdu_op_d | mfhilo_d) & (mdu_busy | mdu_start_e).
- stall_f = stall_d = flush_e = lwstall | brstall | mdustall.
- MDU FSM, 6-bit down-counter cnt:
  - IDLE: on mdu_start_e, load cnt = (mdu_div_e ? DIV_CYCLES : MUL_CYCLES) − 1 and go to BUSY.
  - BUSY: if cnt == 0, go to DONE; else decrement cnt. mdu_start_e is ignored here, since it cannot legally occur.
  - DONE: assert mdu_done. If mdu_start_e, reload cnt and go to BUSY; else go to IDLE.
- mdu_busy and mdu_done are registered state decodes, glitch-free.

## Timing
- Reset (async, immediate): state IDLE, cnt 0, mdu_busy 0, mdu_done 0. While rst = 1, every combinational output is forced to 0.
- Reset mid-operation: the FSM goes to IDLE at once and mdu_done does not pulse.
- Forwarding, stall and flush outputs are purely combinational, with zero-cycle latency from the inputs.
- MDU latency: start seen in cycle t means BUSY for cycles t+1..t+N (N = configured cycles), DONE in cycle t+N+1, IDLE in t+N+2.
- A dependent MDU or mfhi/mflo instruction in decode is stalled in cycles t..t+N and released in the DONE cycle.
- N = 1: BUSY lasts exactly one cycle (cnt loaded with 0).
- Simultaneous lwstall and mdustall: a single combined stall. Release occurs only when every source clears.

## Test plan
- Forwarding priority: rs_e = 5 with MEM (regwrite_m = 1, wreg_m = 5) and WB (wreg_w = 5) both writing → fwd_a_e = 10. Drop MEM → 01. Set wreg_m = wreg_w = 0 with rs_e = 0 → 00.
- Load-use: memtoreg_e = regwrite_e = 1, wreg_e = 8, rt_d = 8 → stall_f = stall_d = flush_e = 1 for one cycle. With wreg_e = 0 → no stall.
- Branch: branch_d = 1, rs_d = 3, regwrite_e = 1, wreg_e = 3 → stall. Next cycle the value is in MEM (ALU op) → no stall, fwd_a_d = 1.
- Multiply: mdu_start_e = 1, mdu_div_e = 0 at cycle 0 with mfhilo_d = 1 held → stall in cycles 0..4, mdu_busy in 1..4, mdu_done and release in cycle 5.
- Divide with reset: start a divide, assert rst in the 10th BUSY cycle → mdu_busy = 0 immediately, no mdu_done, all outputs 0 during reset. After release, state is IDLE.
- Back-to-back: mdu_start_e asserted during DONE → BUSY the next cycle with cnt reloaded, and mdu_done lasts one cycle only.
